// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lets N requesters share one unsigned W x W multiplier.
// One operation is in flight at a time; the product and owner index return on one response channel.
module mult_share_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 3,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*W-1:0]   rsp_y,
  output logic [IDW-1:0]   rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   win;
  logic             hit;
  logic             accept;
  logic [W-1:0]     a_p0, b_p0;
  logic [IDW-1:0]   id_p0;
  int               cand;
  int               nxt;

  function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // First valid requester at or above the pointer, wrapping past N-1.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!hit && req_valid[cand[IDW-1:0]]) begin
        hit = 1'b1;
        win = cand[IDW-1:0];
      end
    end
    nxt = int'(win) + 1;
    if (nxt >= N) nxt = 0;
    ptr_nxt = nxt[IDW-1:0];
  end

  assign accept = (state == IDLE) && hit && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit)       state_nxt = MUL;
      MUL:                    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
    busy = (state != IDLE);
  end

  // Stage p0: operands captured at the request handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= req_a[win*W +: W];
      b_p0  <= req_b[win*W +: W];
      id_p0 <= win;
    end
  end

  // Response stage: product registered out of MUL, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) ptr <= ptr_nxt;
      if (state == MUL) begin
        rsp_y     <= mul_full(a_p0, b_p0);
        rsp_id    <= id_p0;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (N=4, W=3).
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_y;
  logic [1:0]     rsp_id;
  logic           busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mult_share_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (rsp_y !== 6'd0) $display("FAIL reset_rsp_y got %0d want 0", rsp_y); else pass_cnt++;
    chk_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", req_ready); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick();
    req_a[1*W +: W] = 3'd5; req_b[1*W +: W] = 3'd6; req_valid = 4'b0010;
    #1;
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL single_grant got %b want 0010", req_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy); else pass_cnt++;
    tick();
    req_valid = '0;
    #1;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL single_mul_ready got %b want 0000", req_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_mul_busy got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_mul_valid got %b want 0", rsp_valid); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_hold_valid c=%0d got %b want 1", c, rsp_valid); else pass_cnt++;
      chk_cnt++; if (rsp_y !== 6'd30) $display("FAIL single_hold_y c=%0d got %0d want 30", c, rsp_y); else pass_cnt++;
      chk_cnt++; if (rsp_id !== 2'd1) $display("FAIL single_hold_id c=%0d got %0d want 1", c, rsp_id); else pass_cnt++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_cleared got %b want 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_back_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [5:0] ey;
    logic [3:0] eg;
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 3'(i + 1);
      req_b[i*W +: W] = 3'd7;
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      ey = 6'(((g % 4) + 1) * 7);
      #1;
      chk_cnt++; if (req_ready !== eg) $display("FAIL rr_grant g=%0d got %b want %b", g, req_ready, eg); else pass_cnt++;
      tick();
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rr_mul_ready g=%0d got %b want 0000", g, req_ready); else pass_cnt++;
      tick();
      chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rr_valid g=%0d got %b want 1", g, rsp_valid); else pass_cnt++;
      chk_cnt++; if (rsp_y !== ey) $display("FAIL rr_y g=%0d got %0d want %0d", g, rsp_y, ey); else pass_cnt++;
      chk_cnt++; if (rsp_id !== 2'(g % 4)) $display("FAIL rr_id g=%0d got %0d want %0d", g, rsp_id, g % 4); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rr_resp_ready g=%0d got %b want 0000", g, req_ready); else pass_cnt++;
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] vv [3];
    logic [3:0] eg [3];
    logic [5:0] ey [3];
    logic [1:0] ei [3];
    vv = '{4'b0100, 4'b0101, 4'b0101};
    eg = '{4'b0100, 4'b0001, 4'b0100};
    ey = '{6'd20, 6'd6, 6'd20};
    ei = '{2'd2, 2'd0, 2'd2};
    do_reset();
    tick();
    req_a[0 +: W] = 3'd2; req_b[0 +: W] = 3'd3;
    req_a[2*W +: W] = 3'd4; req_b[2*W +: W] = 3'd5;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = vv[k];
      #1;
      chk_cnt++; if (req_ready !== eg[k]) $display("FAIL wrap_grant k=%0d got %b want %b", k, req_ready, eg[k]); else pass_cnt++;
      tick();
      tick();
      chk_cnt++; if (rsp_y !== ey[k]) $display("FAIL wrap_y k=%0d got %0d want %0d", k, rsp_y, ey[k]); else pass_cnt++;
      chk_cnt++; if (rsp_id !== ei[k]) $display("FAIL wrap_id k=%0d got %0d want %0d", k, rsp_id, ei[k]); else pass_cnt++;
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_max_operands();
    logic [2:0] ta [2];
    logic [2:0] tb [2];
    logic [5:0] ty [2];
    ta = '{3'd7, 3'd0};
    tb = '{3'd7, 3'd7};
    ty = '{6'b110001, 6'd0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_a[1*W +: W] = ta[k]; req_b[1*W +: W] = tb[k]; req_valid = 4'b0010;
      #1;
      chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL max_grant k=%0d got %b want 0010", k, req_ready); else pass_cnt++;
      tick();
      tick();
      chk_cnt++; if (rsp_y !== ty[k]) $display("FAIL max_y k=%0d got %0d want %0d", k, rsp_y, ty[k]); else pass_cnt++;
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    tick();
    chk_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle_rsp_ready got valid=%b busy=%b want 0/0", rsp_valid, busy); else pass_cnt++;
    rsp_ready = 1'b0;
    req_a[0 +: W] = 3'd3; req_b[0 +: W] = 3'd3;
    req_a[3*W +: W] = 3'd2; req_b[3*W +: W] = 3'd6;
    req_valid = 4'b0001;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL bp_grant0 got %b want 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = 4'b1000;
    #1;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_mul_ready got %b want 0000", req_ready); else pass_cnt++;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); else pass_cnt++;
      chk_cnt++; if (rsp_y !== 6'd9 || rsp_id !== 2'd0) $display("FAIL bp_hold c=%0d got y=%0d id=%0d want 9/0", c, rsp_y, rsp_id); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1 || rsp_valid !== 1'b1) $display("FAIL bp_busy c=%0d got busy=%b valid=%b want 1/1", c, busy, rsp_valid); else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL bp_grant3 got %b want 1000", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_cleared got %b want 0", rsp_valid); else pass_cnt++;
    tick();
    req_valid = '0;
    tick();
    chk_cnt++; if (rsp_y !== 6'd12 || rsp_id !== 2'd3) $display("FAIL bp_second got y=%0d id=%0d want 12/3", rsp_y, rsp_id); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_a[1*W +: W] = 3'd7; req_b[1*W +: W] = 3'd6; req_valid = 4'b0010;
    #1;
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL rm_grant1 got %b want 0010", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_ctrl got valid=%b busy=%b want 0/0", rsp_valid, busy); else pass_cnt++;
    chk_cnt++; if (rsp_y !== 6'd0 || rsp_id !== 2'd0) $display("FAIL rm_data got y=%0d id=%0d want 0/0", rsp_y, rsp_id); else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_no_response got valid=%b busy=%b want 0/0", rsp_valid, busy); else pass_cnt++;
    req_a[0 +: W] = 3'd1; req_b[0 +: W] = 3'd1;
    req_a[2*W +: W] = 3'd4; req_b[2*W +: W] = 3'd5;
    req_valid = 4'b0101;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rm_ptr_reset got %b want 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    tick();
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_y !== 6'd1 || rsp_id !== 2'd0) $display("FAIL rm_after got valid=%b y=%0d id=%0d want 1/1/0", rsp_valid, rsp_y, rsp_id); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_max_operands();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
